// File: rtl/tile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tile_pkg                                                  |
// | Purpose  : Shared types and constants for the piano-tiles note       |
// |            sequencer: FSM state encoding, control keycodes, default  |
// |            lane keymap and the scroll speed ceiling.                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package tile_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PAUSE  = 3'd1,
      S_SPAWN  = 3'd2,
      S_CHECK  = 3'd3,
      S_FINISH = 3'd4
   } seq_state_t;

   localparam logic [7:0]  START_KEY      = 8'h2C;
   localparam logic [7:0]  ABORT_KEY      = 8'h29;
   // Lane 0 key in the low byte: lane0=04, lane1=16, lane2=07, lane3=09.
   localparam logic [31:0] DEFAULT_KEYMAP = {8'h09, 8'h07, 8'h16, 8'h04};
   localparam logic [3:0]  SPEED_MAX      = 4'd15;

endpackage : tile_pkg
`default_nettype wire

// File: rtl/lane_key_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : lane_key_decoder                                          |
// | Purpose  : Registers, per lane, whether the current keycode matches  |
// |            that lane's key. Lanes sharing a key all assert.          |
// | Ports    : Clk, Reset (sync, active-high), keycode[7:0] in;          |
// |            kill[LANES-1:0] out (registered level, 1-cycle lag).      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module lane_key_decoder
   import tile_pkg::*;
#(
   parameter int                 LANES  = 4,
   parameter logic [8*LANES-1:0] KEYMAP = DEFAULT_KEYMAP
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic [7:0]       keycode,
   output logic [LANES-1:0] kill
);

   logic [LANES-1:0] kill_d;
   logic [LANES-1:0] kill_q;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      assign kill_d[i] = (keycode == KEYMAP[8*i +: 8]);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         kill_q <= '0;
      end else begin
         kill_q <= kill_d;
      end
   end

   assign kill = kill_q;

endmodule : lane_key_decoder
`default_nettype wire

// File: rtl/tile_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tile_sequencer                                            |
// | Purpose  : Piano-tiles note sequencer. On the start key it emits     |
// |            NOTE_COUNT one-hot spawn pulses separated by a pause that |
// |            shrinks per note, tracks song progress and scroll speed,  |
// |            and decodes lane keys into kill levels.                   |
// | Ports    : Clk, Reset (sync, active-high), keycode[7:0],             |
// |            randVal[LANE_W*NOTE_COUNT-1:0] in;                        |
// |            spawn[LANES-1:0], kill[LANES-1:0], speed[3:0],            |
// |            note_idx[7:0], busy, done out.                            |
// | Options  : TILE_SEQ_NOREPEAT_EN - when defined, a lane equal to the  |
// |            previous spawn's lane is bumped to the next lane.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tile_sequencer
   import tile_pkg::*;
#(
   parameter int                 LANES        = 4,
   parameter int                 NOTE_COUNT   = 20,
   parameter int                 PAUSE_CYCLES = 8,
   parameter int                 PAUSE_STEP   = 0,
   parameter int                 PAUSE_MIN    = 1,
   parameter logic [8*LANES-1:0] KEYMAP       = DEFAULT_KEYMAP
) (
   input  logic                                   Clk,
   input  logic                                   Reset,
   input  logic [7:0]                             keycode,
   input  logic [$clog2(LANES)*NOTE_COUNT-1:0]    randVal,
   output logic [LANES-1:0]                       spawn,
   output logic [LANES-1:0]                       kill,
   output logic [3:0]                             speed,
   output logic [7:0]                             note_idx,
   output logic                                   busy,
   output logic                                   done
);

   localparam int LANE_W = $clog2(LANES);
   localparam int RV_W   = LANE_W * NOTE_COUNT;
   // Counter holds pause_len-1; the longest pause is PAUSE_CYCLES.
   localparam int CNT_W  = (PAUSE_CYCLES > 2) ? $clog2(PAUSE_CYCLES) : 1;

   seq_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [7:0]        note_idx_q, note_idx_d;
   logic [3:0]        speed_q, speed_d;

   logic              w_start;
   logic              w_abort;
   logic [RV_W-1:0]   w_rv_shift;
   logic [LANE_W-1:0] w_draw;
   logic [LANE_W-1:0] w_lane;
   logic [7:0]        w_speed_raw;

   // Pause length minus one for the given number of spawned notes. The
   // reduction is done in signed int so a large step clamps to the floor
   // instead of wrapping.
   function automatic logic [CNT_W-1:0] pause_load(input logic [7:0] idx);
      int v;
      v = PAUSE_CYCLES - int'(idx) * PAUSE_STEP;
      if (v < PAUSE_MIN) begin
         v = PAUSE_MIN;
      end
      return CNT_W'(v - 1);
   endfunction

   assign w_start = (state_q == S_IDLE) && (keycode == START_KEY);
   assign w_abort = (state_q != S_IDLE) && (keycode == ABORT_KEY);

   // A shift rather than an indexed part-select keeps out-of-range indices
   // (note_idx == NOTE_COUNT outside SPAWN) well defined.
   assign w_rv_shift = randVal >> (LANE_W * int'(note_idx_q));
   assign w_draw     = w_rv_shift[LANE_W-1:0];

`ifdef TILE_SEQ_NOREPEAT_EN
   logic [LANE_W-1:0] prev_lane_q;

   // The first note of a song is never bumped; LANES is a power of two so
   // the increment wraps naturally.
   assign w_lane = ((note_idx_q != 8'd0) && (w_draw == prev_lane_q))
                   ? (w_draw + LANE_W'(1)) : w_draw;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         prev_lane_q <= '0;
      end else if (w_start) begin
         prev_lane_q <= '0;
      end else if (state_q == S_SPAWN) begin
         prev_lane_q <= w_lane;
      end
   end
`else
   assign w_lane = w_draw;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      note_idx_d = note_idx_q;
      spawn      = '0;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (w_start) begin
               state_d    = S_PAUSE;
               note_idx_d = 8'd0;
               cnt_d      = pause_load(8'd0);
            end
         end
         S_PAUSE: begin
            busy = 1'b1;
            if (cnt_q == '0) begin
               state_d = S_SPAWN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_SPAWN: begin
            busy          = 1'b1;
            spawn[w_lane] = 1'b1;
            note_idx_d    = note_idx_q + 8'd1;
            state_d       = S_CHECK;
         end
         S_CHECK: begin
            busy = 1'b1;
            if (note_idx_q == 8'(NOTE_COUNT)) begin
               state_d = S_FINISH;
            end else begin
               state_d = S_PAUSE;
               cnt_d   = pause_load(note_idx_q);
            end
         end
         S_FINISH: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over every other transition; note_idx keeps whatever the
      // current cycle produced (including a spawn already underway).
      if (w_abort) begin
         state_d = S_IDLE;
      end
   end

   // Speed tracks the registered note count, so it trails it by a cycle.
   assign w_speed_raw = 8'd1 + {1'b0, note_idx_q[7:1]};
   assign speed_d     = (w_speed_raw > {4'd0, SPEED_MAX}) ? SPEED_MAX
                                                          : w_speed_raw[3:0];

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         note_idx_q <= 8'd0;
         speed_q    <= 4'd1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         note_idx_q <= note_idx_d;
         speed_q    <= speed_d;
      end
   end

   lane_key_decoder #(
      .LANES  (LANES),
      .KEYMAP (KEYMAP)
   ) u_keys (
      .Clk     (Clk),
      .Reset   (Reset),
      .keycode (keycode),
      .kill    (kill)
   );

   assign note_idx = note_idx_q;
   assign speed    = speed_q;

endmodule : tile_sequencer
`default_nettype wire

// File: tb/tb_tile_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_tile_sequencer                                         |
// | Purpose  : Self-checking bench for tile_sequencer. Two instances     |
// |            (constant pause, and shrinking pause 8/-3/min 2) share    |
// |            stimulus and are compared each cycle against a song       |
// |            timeline model built from pause lengths and lane draws.   |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_tile_sequencer;

   localparam int NC = 20;
   localparam logic [7:0] LANE_KEY [4] = '{8'h04, 8'h16, 8'h07, 8'h09};

   logic        Clk;
   logic        Reset;
   logic [7:0]  keycode;
   logic [39:0] randVal;

   logic [3:0]  spawn_w [2];
   logic [3:0]  kill_w  [2];
   logic [3:0]  speed_w [2];
   logic [7:0]  idx_w   [2];
   logic        busy_w  [2];
   logic        done_w  [2];

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit         m_act   [2];
   int         m_t     [2];
   int         m_hold  [2];
   logic [3:0] m_speed [2];
   logic [3:0] m_kill;
   int         m_lane  [NC];

   tile_sequencer dut0 (
      .Clk(Clk), .Reset(Reset), .keycode(keycode), .randVal(randVal),
      .spawn(spawn_w[0]), .kill(kill_w[0]), .speed(speed_w[0]),
      .note_idx(idx_w[0]), .busy(busy_w[0]), .done(done_w[0])
   );

   tile_sequencer #(
      .PAUSE_CYCLES(8), .PAUSE_STEP(3), .PAUSE_MIN(2)
   ) dut1 (
      .Clk(Clk), .Reset(Reset), .keycode(keycode), .randVal(randVal),
      .spawn(spawn_w[1]), .kill(kill_w[1]), .speed(speed_w[1]),
      .note_idx(idx_w[1]), .busy(busy_w[1]), .done(done_w[1])
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic int plen(input int d, input int n);
      int v;
      if (d == 0) v = 8;
      else        v = 8 - 3 * n;
      if (d == 1 && v < 2) v = 2;
      if (v < 1) v = 1;
      return v;
   endfunction

   // kind: 0 pause, 1 spawn, 2 check, 3 finish, 4 past end
   function automatic void phase_of(input int d, input int t,
                                    output int kind, output int n);
      int r;
      r = t;
      for (int i = 0; i < NC; i++) begin
         if (r < plen(d, i))       begin kind = 0; n = i; return; end
         if (r == plen(d, i))      begin kind = 1; n = i; return; end
         if (r == plen(d, i) + 1)  begin kind = 2; n = i; return; end
         r = r - (plen(d, i) + 2);
      end
      n    = NC;
      kind = (r == 0) ? 3 : 4;
   endfunction

   function automatic bit in_phase(input int d, input int kind, input int n);
      int k, m;
      if (!m_act[d]) return 1'b0;
      phase_of(d, m_t[d], k, m);
      return (k == kind) && (m == n);
   endfunction

   function automatic logic [3:0] kill_of(input logic [7:0] kc);
      logic [3:0] k;
      for (int i = 0; i < 4; i++) k[i] = (kc == LANE_KEY[i]);
      return k;
   endfunction

   task automatic draw_lanes();
      int draw;
      for (int i = 0; i < NC; i++) begin
         draw = int'((randVal >> (2 * i)) & 40'd3);
`ifdef TILE_SEQ_NOREPEAT_EN
         if (i > 0 && draw == m_lane[i-1]) draw = (draw + 1) % 4;
`endif
         m_lane[i] = draw;
      end
   endtask

   task automatic exp_out(input int d, output logic b, output logic dn,
                          output logic [3:0] sp, output logic [7:0] ix);
      int k, n;
      if (!m_act[d]) begin
         b = 1'b0; dn = 1'b0; sp = 4'd0; ix = 8'(m_hold[d]);
      end else begin
         phase_of(d, m_t[d], k, n);
         b  = (k < 3);
         dn = (k == 3);
         sp = (k == 1) ? 4'(1 << m_lane[n]) : 4'd0;
         ix = (k == 2) ? 8'(n + 1) : 8'(n);
      end
   endtask

   // Advance the model across one rising edge using the sampled inputs.
   task automatic model_edge();
      logic b, dn;
      logic [3:0] sp;
      logic [7:0] ix;
      int k, n, s;
      for (int d = 0; d < 2; d++) begin
         exp_out(d, b, dn, sp, ix);
         if (Reset) begin
            m_act[d] = 1'b0; m_hold[d] = 0; m_speed[d] = 4'd1;
         end else begin
            s = 1 + int'(ix) / 2;
            m_speed[d] = (s > 15) ? 4'd15 : 4'(s);
            if (!m_act[d]) begin
               if (keycode == 8'h2C) begin
                  m_act[d] = 1'b1; m_t[d] = 0; m_hold[d] = 0;
                  draw_lanes();
               end
            end else begin
               phase_of(d, m_t[d], k, n);
               if (keycode == 8'h29) begin
                  m_act[d]  = 1'b0;
                  m_hold[d] = (k == 1) ? n + 1 : int'(ix);
               end else if (k == 3) begin
                  m_act[d]  = 1'b0;
                  m_hold[d] = NC;
               end else begin
                  m_t[d] = m_t[d] + 1;
               end
            end
         end
      end
      m_kill = Reset ? 4'd0 : kill_of(keycode);
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic b, dn;
      logic [3:0] sp;
      logic [7:0] ix;
      for (int d = 0; d < 2; d++) begin
         exp_out(d, b, dn, sp, ix);
         chk($sformatf("busy%0d", d),  32'(busy_w[d]),  32'(b));
         chk($sformatf("done%0d", d),  32'(done_w[d]),  32'(dn));
         chk($sformatf("spawn%0d", d), 32'(spawn_w[d]), 32'(sp));
         chk($sformatf("idx%0d", d),   32'(idx_w[d]),   32'(ix));
         chk($sformatf("speed%0d", d), 32'(speed_w[d]), 32'(m_speed[d]));
         chk($sformatf("kill%0d", d),  32'(kill_w[d]),  32'(m_kill));
      end
   endtask

   task automatic cycle();
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
      check_all();
   endtask

   task automatic run_until_idle(input int budget);
      int k;
      k = 0;
      while ((m_act[0] || m_act[1]) && k < budget) begin
         cycle();
         k++;
      end
      chk("idle_timeout", 32'(k < budget), 32'd1);
   endtask

   task automatic start_song();
      keycode = 8'h2C;
      cycle();
      keycode = 8'h00;
   endtask

   logic [7:0] rkeys [6];
   int         sp_t0[$], sp_t1[$];
   logic [3:0] sp_v0[$];
   int         done_t, k, bad;

   initial begin
      rkeys = '{8'h00, 8'h04, 8'h16, 8'h07, 8'h09, 8'h55};
      for (int d = 0; d < 2; d++) begin
         m_act[d] = 1'b0; m_t[d] = 0; m_hold[d] = 0; m_speed[d] = 4'd1;
      end
      m_kill  = 4'd0;
      Reset   = 1'b1;
      keycode = 8'h00;
      randVal = '0;

      // Reset state
      repeat (3) cycle();
      Reset = 1'b0;
      cycle();

      // Idle key decoding, random mapped/unmapped keys
      repeat (12) begin
         keycode = rkeys[$urandom_range(0, 5)];
         cycle();
      end
      keycode = 8'h00;
      cycle();

      // Song with lanes 0,1,2,3,... : timing of both instances
      for (int i = 0; i < NC; i++) randVal[2*i +: 2] = 2'(i % 4);
      start_song();
      k = 1; done_t = -1;
      while ((m_act[0] || m_act[1]) && k < 600) begin
         if (spawn_w[0] != 4'd0) begin sp_t0.push_back(k); sp_v0.push_back(spawn_w[0]); end
         if (spawn_w[1] != 4'd0) sp_t1.push_back(k);
         if (done_w[0]) done_t = k;
         cycle();
         k++;
      end
      chk("songA_timeout", 32'(k < 600), 32'd1);
      chk("songA_count", 32'(sp_t0.size()), 32'(NC));
      if (sp_t0.size() == NC) begin
         chk("first_spawn_latency", 32'(sp_t0[0]), 32'd9);
         bad = 0;
         for (int i = 1; i < NC; i++) if (sp_t0[i] - sp_t0[i-1] != 10) bad++;
         chk("note_period_bad", 32'(bad), 32'd0);
         bad = 0;
         for (int i = 0; i < NC; i++) if (sp_v0[i] != 4'(1 << (i % 4))) bad++;
         chk("lane_order_bad", 32'(bad), 32'd0);
         chk("done_after_last", 32'(done_t), 32'(sp_t0[NC-1] + 2));
      end
      chk("final_speed", 32'(speed_w[0]), 32'd11);
      if (sp_t1.size() >= 4) begin
         chk("ramp_first", 32'(sp_t1[0]), 32'd9);
         chk("ramp_gap1", 32'(sp_t1[1] - sp_t1[0]), 32'd7);
         chk("ramp_gap2", 32'(sp_t1[2] - sp_t1[1]), 32'd4);
         chk("ramp_gap3", 32'(sp_t1[3] - sp_t1[2]), 32'd4);
      end else begin
         chk("ramp_count", 32'(sp_t1.size()), 32'(NC));
      end

      // Abort in the pause after 5 notes, then restart
      randVal = 40'({$urandom(), $urandom()});
      start_song();
      k = 0;
      while (!in_phase(0, 0, 5) && k < 400) begin cycle(); k++; end
      chk("abort_wait", 32'(k < 400), 32'd1);
      keycode = 8'h29;
      cycle();
      keycode = 8'h00;
      chk("abort_busy", 32'(busy_w[0]), 32'd0);
      chk("abort_idx", 32'(idx_w[0]), 32'd5);
      repeat (4) cycle();
      start_song();
      chk("restart_idx", 32'(idx_w[0]), 32'd0);
      chk("restart_busy", 32'(busy_w[0]), 32'd1);

      // Key hold on lane 2, then start key while busy
      keycode = 8'h07;
      repeat (3) begin
         cycle();
         chk("kill_hold", 32'(kill_w[0]), 32'h4);
      end
      keycode = 8'h00;
      cycle();
      chk("kill_release", 32'(kill_w[0]), 32'h0);
      keycode = 8'h2C;
      cycle();
      keycode = 8'h00;
      chk("start_while_busy", 32'(busy_w[0]), 32'd1);

      // Random key traffic through the rest of the song
      repeat (80) begin
         keycode = rkeys[$urandom_range(0, 5)];
         cycle();
      end
      keycode = 8'h00;
      run_until_idle(400);

      // All draws on lane 2
      randVal = {NC{2'b10}};
      start_song();
      sp_v0.delete();
      k = 0;
      while (sp_v0.size() < 2 && k < 100) begin
         if (spawn_w[0] != 4'd0) sp_v0.push_back(spawn_w[0]);
         cycle();
         k++;
      end
      chk("repeat_wait", 32'(k < 100), 32'd1);
      if (sp_v0.size() == 2) begin
         chk("repeat_first", 32'(sp_v0[0]), 32'h4);
`ifdef TILE_SEQ_NOREPEAT_EN
         chk("repeat_second", 32'(sp_v0[1]), 32'h8);
`else
         chk("repeat_second", 32'(sp_v0[1]), 32'h4);
`endif
      end
      run_until_idle(400);

      // Reset during the spawn of note 7
      randVal = 40'({$urandom(), $urandom()});
      start_song();
      k = 0;
      while (!in_phase(0, 1, 7) && k < 400) begin cycle(); k++; end
      chk("reset_wait", 32'(k < 400), 32'd1);
      keycode = 8'h16;
      Reset   = 1'b1;
      cycle();
      Reset   = 1'b0;
      keycode = 8'h00;
      chk("rst_spawn", 32'(spawn_w[0]), 32'd0);
      chk("rst_kill",  32'(kill_w[0]),  32'd0);
      chk("rst_idx",   32'(idx_w[0]),   32'd0);
      chk("rst_speed", 32'(speed_w[0]), 32'd1);
      chk("rst_busy",  32'(busy_w[0]),  32'd0);
      chk("rst_done",  32'(done_w[0]),  32'd0);
      repeat (6) cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_tile_sequencer
`default_nettype wire
